// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external memory port controller.
package ext_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp,
    StRecover
  } ext_mem_state_e;

  localparam logic [31:0]  EXT_MEM_ERR_DATA = 32'hDEAD_BEEF;
  localparam int unsigned  ExtMemWaitCntW   = 4;

endpackage

// File: rtl/ext_mem_controller_if.sv
// Request/response signals of the processor's ext_* memory port.
interface ext_mem_controller_if;
  logic [31:0] ext_addr;
  logic        ext_mem_read;
  logic        ext_mem_write;
  logic        ext_mem_enable;
  logic        ext_mem_ready;
  logic        bus_error;
  logic [31:0] access_count;

  modport master (
    output ext_addr, ext_mem_read, ext_mem_write, ext_mem_enable,
    input  ext_mem_ready, bus_error, access_count
  );

  modport slave (
    input  ext_addr, ext_mem_read, ext_mem_write, ext_mem_enable,
    output ext_mem_ready, bus_error, access_count
  );
endinterface

// File: rtl/ext_mem_array.sv
// Single-port word RAM with synchronous write and a registered read port.
module ext_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_mem_controller.sv
// Slave controller for the ext_* port: window decode, programmable wait states,
// word access to a local array, one-cycle ready pulse with error qualifier.
module ext_mem_controller
  import ext_mem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ext_mem_controller_if.slave  bus,
  inout  wire  [31:0]          ext_data
);

  localparam int unsigned AddrW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] WinSize = 33'(DEPTH_WORDS) << 2;

  ext_mem_state_e              state_q, state_d;
  logic [ExtMemWaitCntW-1:0]   wait_q, wait_d;
  logic [AddrW-1:0]            idx_q, idx_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic                        rd_q, rd_d;
  logic                        wr_q, wr_d;
  logic                        err_q, err_d;
  logic [31:0]                 count_q, count_d;

  logic                        req;
  logic [32:0]                 offset;
  logic                        dec_err;
  logic [AddrW-1:0]            idx_in;
  logic                        ram_we, ram_re;
  logic [AddrW-1:0]            ram_addr;
  logic [31:0]                 ram_rdata;
  logic                        drive_en;

  assign req    = bus.ext_mem_enable && (bus.ext_mem_read || bus.ext_mem_write);
  // 33-bit offset: addresses below the base wrap into bit 32 and fail the size compare.
  assign offset = {1'b0, bus.ext_addr} - {1'b0, ADDR_BASE};
  assign idx_in = offset[AddrW+1:2];
  assign dec_err = (offset >= WinSize) || (offset[1:0] != 2'b00) ||
                   (bus.ext_mem_read && bus.ext_mem_write);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d   = idx_in;
          wdata_d = ext_data;
          rd_d    = bus.ext_mem_read;
          wr_d    = bus.ext_mem_write;
          err_d   = dec_err;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            wait_d  = ExtMemWaitCntW'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        wait_d = wait_q - ExtMemWaitCntW'(1);
        if (wait_q <= ExtMemWaitCntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StRecover;
        if (!err_q && (count_q != 32'hFFFF_FFFF)) begin
          count_d = count_q + 32'd1;
        end
      end
      StRecover: begin
        if (!bus.ext_mem_enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // The read is launched on the edge entering RESP; with no wait states that
  // edge is the accepting one, so the index comes straight from the bus.
  assign ram_re   = (state_d == StResp);
  assign ram_we   = (state_q == StResp) && wr_q && !err_q;
  assign ram_addr = (state_q == StIdle) ? idx_in : idx_q;

  ext_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign drive_en          = (state_q == StResp) && rd_q;
  assign ext_data          = drive_en ? (err_q ? EXT_MEM_ERR_DATA : ram_rdata) : 32'bz;
  assign bus.ext_mem_ready = (state_q == StResp);
  assign bus.bus_error     = (state_q == StResp) && err_q;
  assign bus.access_count  = count_q;

endmodule

// File: tb/tb_ext_mem_controller.sv
// Directed bench: one DUT with two wait states, one with none, sharing a stimulus driver.
module tb_ext_mem_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        t_sel, t_rd, t_wr, t_en, t_drv_en;
  logic [31:0] t_addr, t_drv_data;
  int          checks = 0;
  int          errors = 0;

  ext_mem_controller_if bus ();
  ext_mem_controller_if bus0 ();
  wire [31:0] ext_data;
  wire [31:0] ext_data0;

  assign bus.ext_addr        = t_addr;
  assign bus.ext_mem_read    = t_rd;
  assign bus.ext_mem_write   = t_wr;
  assign bus.ext_mem_enable  = t_en && !t_sel;
  assign bus0.ext_addr       = t_addr;
  assign bus0.ext_mem_read   = t_rd;
  assign bus0.ext_mem_write  = t_wr;
  assign bus0.ext_mem_enable = t_en && t_sel;
  assign ext_data  = (t_drv_en && !t_sel) ? t_drv_data : 32'bz;
  assign ext_data0 = (t_drv_en &&  t_sel) ? t_drv_data : 32'bz;

  logic        obs_ready, obs_err;
  logic [31:0] obs_data;
  assign obs_ready = t_sel ? bus0.ext_mem_ready : bus.ext_mem_ready;
  assign obs_err   = t_sel ? bus0.bus_error     : bus.bus_error;
  assign obs_data  = t_sel ? ext_data0          : ext_data;

  ext_mem_controller #(
    .ADDR_BASE   (32'h0001_0000),
    .DEPTH_WORDS (1024),
    .WAIT_STATES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ext_data (ext_data)
  );

  ext_mem_controller #(
    .ADDR_BASE   (32'h0001_0000),
    .DEPTH_WORDS (1024),
    .WAIT_STATES (0)
  ) dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus0),
    .ext_data (ext_data0)
  );

  // Issues one access, drops the strobe and scrambles the request right after
  // acceptance, and reports latency (edges from acceptance; 99 = timed out).
  task automatic do_access(input logic sel, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output logic one_pulse);
    @(negedge clk);
    t_sel = sel; t_addr = addr; t_rd = rd; t_wr = wr; t_en = 1'b1;
    t_drv_en = !rd; t_drv_data = wdata;
    lat = 99; err = 1'b0; rdata = '0; one_pulse = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        t_en = 1'b0; t_addr = ~addr; t_drv_data = ~wdata; t_rd = wr; t_wr = rd;
      end
      if (obs_ready) begin
        lat = i; err = obs_err; rdata = obs_data;
        break;
      end
    end
    @(posedge clk); #1;
    one_pulse = !obs_ready;
    @(posedge clk); #1;
    t_rd = 1'b0; t_wr = 1'b0; t_drv_en = 1'b1; t_drv_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ext_mem_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", bus.ext_mem_ready);
    end
    checks++;
    if (bus.bus_error !== 1'b0) begin
      errors++; $display("FAIL reset_bus_error got %b want 0", bus.bus_error);
    end
    checks++;
    if (bus.access_count !== 32'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", bus.access_count);
    end
    checks++;
    if (bus0.access_count !== 32'd0) begin
      errors++; $display("FAIL reset_count_ws0 got %0d want 0", bus0.access_count);
    end
    checks++;
    if (ext_data !== 32'd0) begin
      errors++; $display("FAIL reset_bus_quiet got %h want 00000000", ext_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic err, pulse; logic [31:0] rd;
    do_access(1'b0, 1'b0, 1'b1, 32'h0001_0008, 32'd50000, lat, err, rd, pulse);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL wr_error got %b want 0", err); end
    checks++;
    if (pulse !== 1'b1) begin errors++; $display("FAIL wr_single_pulse got %b want 1", pulse); end
    do_access(1'b0, 1'b1, 1'b0, 32'h0001_0008, 32'd0, lat, err, rd, pulse);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rd_error got %b want 0", err); end
    checks++;
    if (rd !== 32'd50000) begin errors++; $display("FAIL rd_data got %0d want 50000", rd); end
    checks++;
    if (bus.access_count !== 32'd2) begin
      errors++; $display("FAIL wr_rd_count got %0d want 2", bus.access_count);
    end
  endtask

  task automatic test_zero_wait();
    int lat; logic err, pulse; logic [31:0] rd;
    do_access(1'b1, 1'b0, 1'b1, 32'h0001_0010, 32'h1234_5678, lat, err, rd, pulse);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL ws0_wr_latency got %0d want 1", lat); end
    do_access(1'b1, 1'b1, 1'b0, 32'h0001_0010, 32'd0, lat, err, rd, pulse);
    checks++;
    if (lat != 1) begin errors++; $display("FAIL ws0_rd_latency got %0d want 1", lat); end
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++; $display("FAIL ws0_rd_data got %h want 12345678", rd);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL ws0_rd_error got %b want 0", err); end
    checks++;
    if (bus0.access_count !== 32'd2) begin
      errors++; $display("FAIL ws0_count got %0d want 2", bus0.access_count);
    end
  endtask

  task automatic test_errors();
    int lat; logic err, pulse; logic [31:0] rd;
    do_access(1'b0, 1'b1, 1'b0, 32'h0001_1000, 32'd0, lat, err, rd, pulse);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL past_end_error got %b want 1", err); end
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL past_end_data got %h want deadbeef", rd);
    end
    checks++;
    if (bus.access_count !== 32'd2) begin
      errors++; $display("FAIL past_end_count got %0d want 2", bus.access_count);
    end
    do_access(1'b0, 1'b0, 1'b1, 32'h0001_0000, 32'hA5A5_0001, lat, err, rd, pulse);
    do_access(1'b0, 1'b0, 1'b1, 32'h0001_0002, 32'h1111_2222, lat, err, rd, pulse);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL misaligned_error got %b want 1", err); end
    do_access(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'd0, lat, err, rd, pulse);
    checks++;
    if (rd !== 32'hA5A5_0001) begin
      errors++; $display("FAIL misaligned_unmodified got %h want a5a50001", rd);
    end
    do_access(1'b0, 1'b1, 1'b0, 32'h0000_FFFC, 32'd0, lat, err, rd, pulse);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL below_base_error got %b want 1", err); end
    checks++;
    if (bus.access_count !== 32'd4) begin
      errors++; $display("FAIL errors_count got %0d want 4", bus.access_count);
    end
  endtask

  task automatic test_held_strobe();
    int pulses, lat; logic err, pulse; logic [31:0] rd;
    @(negedge clk);
    t_sel = 1'b0; t_addr = 32'h0001_0004; t_rd = 1'b0; t_wr = 1'b1; t_en = 1'b1;
    t_drv_en = 1'b1; t_drv_data = 32'h0000_0777;
    pulses = 0;
    repeat (13) begin
      @(posedge clk); #1;
      if (obs_ready) pulses++;
    end
    @(negedge clk);
    t_en = 1'b0; t_wr = 1'b0; t_drv_data = '0;
    repeat (3) begin
      @(posedge clk); #1;
      if (obs_ready) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses); end
    checks++;
    if (bus.access_count !== 32'd5) begin
      errors++; $display("FAIL held_count got %0d want 5", bus.access_count);
    end
    do_access(1'b0, 1'b1, 1'b0, 32'h0001_0004, 32'd0, lat, err, rd, pulse);
    checks++;
    if (rd !== 32'h0000_0777) begin
      errors++; $display("FAIL held_readback got %h want 00000777", rd);
    end
  endtask

  task automatic test_reset_mid();
    int pulses, lat; logic err, pulse, seen; logic [31:0] rd;
    @(negedge clk);
    t_sel = 1'b0; t_addr = 32'h0001_0000; t_rd = 1'b0; t_wr = 1'b1; t_en = 1'b1;
    t_drv_en = 1'b1; t_drv_data = 32'hFFFF_FFFF;
    pulses = 0;
    @(posedge clk); #1;
    if (obs_ready) pulses++;
    @(negedge clk);
    rst = 1'b1; t_en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (obs_ready) pulses++;
    end
    @(negedge clk);
    rst = 1'b0; t_wr = 1'b0; t_drv_data = '0;
    repeat (6) begin
      @(posedge clk); #1;
      if (obs_ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rst_mid_pulses got %0d want 0", pulses); end
    checks++;
    if (bus.access_count !== 32'd0) begin
      errors++; $display("FAIL rst_mid_count got %0d want 0", bus.access_count);
    end
    checks++;
    if (ext_data !== 32'd0) begin
      errors++; $display("FAIL rst_mid_bus_quiet got %h want 00000000", ext_data);
    end
    do_access(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'd0, lat, err, rd, pulse);
    checks++;
    if (rd !== 32'hA5A5_0001) begin
      errors++; $display("FAIL rst_mid_word_kept got %h want a5a50001", rd);
    end
    // Reset while a read is in RESP must release ready and the bus without a clock edge.
    @(negedge clk);
    t_addr = 32'h0001_0000; t_rd = 1'b1; t_wr = 1'b0; t_en = 1'b1; t_drv_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      t_en = 1'b0;
      if (obs_ready) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL async_rd_reached got %b want 1", seen); end
    rst = 1'b1; t_drv_en = 1'b1; t_drv_data = '0;
    #1;
    checks++;
    if (bus.ext_mem_ready !== 1'b0) begin
      errors++; $display("FAIL async_ready_drop got %b want 0", bus.ext_mem_ready);
    end
    checks++;
    if (ext_data !== 32'd0) begin
      errors++; $display("FAIL async_bus_release got %h want 00000000", ext_data);
    end
    @(negedge clk);
    rst = 1'b0; t_rd = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.access_count !== 32'd0) begin
      errors++; $display("FAIL async_count got %0d want 0", bus.access_count);
    end
  endtask

  task automatic test_last_word();
    int lat; logic err, pulse; logic [31:0] rd;
    do_access(1'b0, 1'b0, 1'b1, 32'h0001_0FFC, 32'h0BAD_F00D, lat, err, rd, pulse);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL last_wr_error got %b want 0", err); end
    do_access(1'b0, 1'b1, 1'b0, 32'h0001_0FFC, 32'd0, lat, err, rd, pulse);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL last_rd_error got %b want 0", err); end
    checks++;
    if (rd !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL last_rd_data got %h want 0badf00d", rd);
    end
    do_access(1'b0, 1'b1, 1'b1, 32'h0001_0FFC, 32'd0, lat, err, rd, pulse);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL both_ops_error got %b want 1", err); end
    do_access(1'b0, 1'b1, 1'b0, 32'h0001_0FFC, 32'd0, lat, err, rd, pulse);
    checks++;
    if (rd !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL both_ops_unmodified got %h want 0badf00d", rd);
    end
    checks++;
    if (bus.access_count !== 32'd3) begin
      errors++; $display("FAIL last_count got %0d want 3", bus.access_count);
    end
  endtask

  initial begin
    t_sel = 1'b0; t_rd = 1'b0; t_wr = 1'b0; t_en = 1'b0;
    t_addr = '0; t_drv_en = 1'b1; t_drv_data = '0;
    test_reset();
    test_write_read();
    test_zero_wait();
    test_errors();
    test_held_strobe();
    test_reset_mid();
    test_last_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
